// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//   Copies NUM_OF_WORDS 32-bit message words from a source region of a shared
//   single-port, word-addressed memory into a destination region. It then
//   appends SHA-256 padding: a 0x80000000 marker word, zero fill, and a 64-bit
//   big-endian bit length. The padded region is always a whole number of
//   512-bit (16-word) blocks.
//
//   Optional build macro SHA_PAD_BSWAP_EN: when defined, each copied message
//   word is byte-reversed before it is written (little-endian source). The
//   marker, zero and length words are never swapped.
//
//   Memory timing: the memory is synchronous and read data arrives one cycle
//   after the address. Each message word therefore takes three cycles:
//   RD (present the source address), WAIT (capture the read data) and
//   WR (write the captured word). Each padding word then takes one write cycle.

module sha256_msg_padder #(
  parameter int unsigned NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] padded_addr,
  output logic        busy,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // Geometry of the padded message. The marker word plus the two length words
  // need three words of room. floor((N+2)/16)+1 is the smallest block count
  // with 16*B >= N+3.
  localparam int unsigned NUM_BLOCKS = (NUM_OF_WORDS + 2) / 16 + 1;
  localparam logic [27:0] NW_C       = 28'(NUM_OF_WORDS);
  localparam logic [27:0] PAD_LEN_C  = 28'(NUM_BLOCKS * 16);
  localparam logic [27:0] LAST_IDX_C = PAD_LEN_C - 28'd1;
  localparam logic [31:0] LEN_LO_C   = 32'(NUM_OF_WORDS * 32);
  localparam logic [31:0] MARKER_C   = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_PAD  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // Reverses the byte order of a 32-bit word.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Returns the padding word for a given index of the padded message. The
  // index lies in the range NUM_OF_WORDS..P-1. The length high word at P-2 is
  // always zero, because the message length stays below 2^32 bits.
  function automatic logic [31:0] pad_word(input logic [27:0] idx);
    logic [31:0] w;
    if (idx == NW_C) begin
      w = MARKER_C;
    end else if (idx == LAST_IDX_C) begin
      w = LEN_LO_C;
    end else begin
      w = 32'h0000_0000;
    end
    return w;
  endfunction

  // Conditions a freshly read source word before it is stored for writing.
  function automatic logic [31:0] src_word(input logic [31:0] w);
`ifdef SHA_PAD_BSWAP_EN
    return byte_swap32(w);
`else
    return w;
`endif
  endfunction

  state_t      state_q, state_d;
  logic [27:0] idx_q, idx_d;
  logic [15:0] msg_base_q, msg_base_d;
  logic [15:0] pad_base_q, pad_base_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // The memory runs on the same clock as the padder.
  assign mem_clk = clk;

  assign busy = busy_q;
  assign done = done_q;

  // State register, word index, latched base addresses, captured word and
  // status flags. The async reset returns everything to idle at once and
  // leaves the destination region exactly as partly written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 28'd0;
      msg_base_q <= 16'h0000;
      pad_base_q <= 16'h0000;
      data_q     <= 32'h0000_0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      msg_base_q <= msg_base_d;
      pad_base_q <= pad_base_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic and memory port drive. All address arithmetic wraps
  // modulo 2^16, so regions that cross 0xFFFF wrap silently.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    msg_base_d     = msg_base_q;
    pad_base_d     = pad_base_q;
    data_d         = data_q;
    mem_we         = 1'b0;
    mem_addr       = 16'h0000;
    mem_write_data = 32'h0000_0000;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          msg_base_d = message_addr;
          pad_base_d = padded_addr;
          idx_d      = 28'd0;
          state_d    = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RD: begin
        mem_addr = msg_base_q + idx_q[15:0];
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        data_d  = src_word(mem_read_data);
        state_d = S_WR;
      end

      S_WR: begin
        mem_we         = 1'b1;
        mem_addr       = pad_base_q + idx_q[15:0];
        mem_write_data = data_q;
        idx_d          = idx_q + 28'd1;
        if (idx_d == NW_C) begin
          state_d = S_PAD;
        end else begin
          state_d = S_RD;
        end
      end

      S_PAD: begin
        mem_we         = 1'b1;
        mem_addr       = pad_base_q + idx_q[15:0];
        mem_write_data = pad_word(idx_q);
        idx_d          = idx_q + 28'd1;
        if (idx_q == LAST_IDX_C) begin
          state_d = S_FIN;
        end else begin
          state_d = S_PAD;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state. As a result, busy covers
  // RD..PAD and done is a single pulse that coincides with FIN.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_RD, S_WAIT, S_WR, S_PAD: busy_d = 1'b1;
      S_FIN:                     done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder. Three instances (N=20, N=13, N=14) share the
// clock and reset. Each instance has its own synchronous memory model.
// Source reads return a fixed function of the address. Writes land in a
// per-instance array that is pre-filled with a sentinel value.

module tb_sha256_msg_padder;

  localparam int NI = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NI-1:0]   start_v;
  logic [NI-1:0]   busy_v, done_v, mclk_v, we_v;
  logic [15:0]     msg_v   [NI];
  logic [15:0]     pad_v   [NI];
  logic [15:0]     maddr_v [NI];
  logic [31:0]     wdata_v [NI];
  logic [31:0]     rdata_v [NI];
  logic [31:0]     wr_mem  [NI][65536];
  int unsigned     wr_cnt  [NI];
  logic            filled = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NWG = (g == 0) ? 20 : ((g == 1) ? 13 : 14);
    sha256_msg_padder #(.NUM_OF_WORDS(NWG)) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start_v[g]),
      .message_addr   (msg_v[g]),
      .padded_addr    (pad_v[g]),
      .busy           (busy_v[g]),
      .done           (done_v[g]),
      .mem_clk        (mclk_v[g]),
      .mem_we         (we_v[g]),
      .mem_addr       (maddr_v[g]),
      .mem_write_data (wdata_v[g]),
      .mem_read_data  (rdata_v[g])
    );
  end

  // Source word stored at a given address: address minus 0xFF, so that
  // addresses 0x0100.. hold 1, 2, 3, ...
  function automatic logic [31:0] exp_src(input logic [15:0] a);
    return {16'h0000, a} - 32'h0000_00FF;
  endfunction

  // Expected copy of a source word in the destination region.
  function automatic logic [31:0] exp_cp(input logic [15:0] a);
    logic [31:0] w;
    w = exp_src(a);
`ifdef SHA_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Memory model: a one-cycle synchronous read plus write capture. The first
  // clock fills the write arrays with a sentinel value.
  always @(posedge clk) begin
    if (!filled) begin
      for (int g = 0; g < NI; g++) begin
        for (int a = 0; a < 65536; a++) wr_mem[g][a] <= 32'hDEAD_BEEF;
        wr_cnt[g] <= 0;
      end
      filled <= 1'b1;
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (we_v[g]) begin
          wr_mem[g][maddr_v[g]] <= wdata_v[g];
          wr_cnt[g]             <= wr_cnt[g] + 1;
        end
      end
    end
    for (int g = 0; g < NI; g++) rdata_v[g] <= exp_src(maddr_v[g]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One padding run on instance g. If ign is set, start is also pulsed with
  // foreign addresses during RD (cycle 4) and during PAD (cycle 65).
  task automatic run(input int g, input int nw, input logic [15:0] ma,
                     input logic [15:0] pa, input bit ign);
    int          p, exp_done, first_done, n_done;
    int unsigned c0;
    logic [15:0] aj;
    logic [31:0] ew;
    p        = 16 * ((nw + 2) / 16 + 1);
    exp_done = 2 * nw + p + 1;
    @(negedge clk);
    msg_v[g]   = ma;
    pad_v[g]   = pa;
    start_v[g] = 1'b1;
    c0         = wr_cnt[g];
    first_done = 0;
    n_done     = 0;
    for (int k = 1; k <= exp_done + 3; k++) begin
      @(posedge clk); #1;
      start_v[g] = 1'b0;
      msg_v[g]   = ma;
      pad_v[g]   = pa;
      if (ign && (k == 4 || k == 65)) begin
        start_v[g] = 1'b1;
        msg_v[g]   = 16'h7000;
        pad_v[g]   = 16'h7800;
      end
      if (k == 1) begin
        chk("rd_addr", {16'h0000, maddr_v[g]}, {16'h0000, ma});
        chk("rd_we", {31'd0, we_v[g]}, 32'd0);
      end
      if (k == 3) begin
        chk("wr_addr", {16'h0000, maddr_v[g]}, {16'h0000, pa});
        chk("wr_we", {31'd0, we_v[g]}, 32'd1);
      end
      if (k == exp_done - 1) chk("busy_run", {31'd0, busy_v[g]}, 32'd1);
      if (done_v[g]) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    chk("done_cyc", 32'(first_done), 32'(exp_done));
    chk("done_cnt", 32'(n_done), 32'd1);
    chk("busy_end", {31'd0, busy_v[g]}, 32'd0);
    chk("n_writes", 32'(wr_cnt[g] - c0), 32'(p));
    for (int j = 0; j < p; j++) begin
      aj = pa + 16'(j);
      if (j < nw)          ew = exp_cp(ma + 16'(j));
      else if (j == nw)    ew = 32'h8000_0000;
      else if (j == p - 1) ew = 32'(nw * 32);
      else                 ew = 32'h0000_0000;
      chk("pad_word", wr_mem[g][aj], ew);
    end
  endtask

  // Reset asserted in cycle 10 of an N=20 run on instance 0.
  task automatic reset_mid_run();
    int unsigned c0;
    @(negedge clk);
    msg_v[0]   = 16'h0100;
    pad_v[0]   = 16'h4000;
    start_v[0] = 1'b1;
    c0         = wr_cnt[0];
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("rst_done", {31'd0, done_v[0]}, 32'd0);
    chk("rst_we", {31'd0, we_v[0]}, 32'd0);
    chk("rst_addr", {16'h0000, maddr_v[0]}, 32'd0);
    chk("rst_wdata", wdata_v[0], 32'd0);
    chk("rst_writes", 32'(wr_cnt[0] - c0), 32'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_nowr", 32'(wr_cnt[0] - c0), 32'd3);
    chk("rst_idle", {31'd0, busy_v[0]}, 32'd0);
  endtask

  initial begin
    start_v = '0;
    for (int g = 0; g < NI; g++) begin
      msg_v[g] = 16'h0000;
      pad_v[g] = 16'h0000;
    end
    reset_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_busy", {29'd0, busy_v}, 32'd0);
    chk("reset_done", {29'd0, done_v}, 32'd0);
    chk("reset_we", {29'd0, we_v}, 32'd0);
    chk("reset_addr", {16'h0000, maddr_v[0]}, 32'd0);
    chk("reset_wdata", wdata_v[0], 32'd0);
    chk("mem_clk_hi", {29'd0, mclk_v}, 32'd7);
    @(negedge clk); #1;
    chk("mem_clk_lo", {29'd0, mclk_v}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run(0, 20, 16'h0100, 16'h1000, 1'b0);
    run(1, 13, 16'h0100, 16'h1000, 1'b0);
    run(2, 14, 16'hFFFC, 16'hFFF8, 1'b0);
    run(0, 20, 16'h0200, 16'h2000, 1'b1);
    reset_mid_run();
    run(0, 20, 16'h0100, 16'h3000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream stage of the SHA-256 hasher: copies an unpadded message of `NUM_OF_WORDS` 32-bit words from shared word-addressed memory into a padded-message region and appends standard SHA-256 padding (0x80000000 marker, zero fill, 64-bit big-endian bit length). The hasher is then started on the padded region, which holds an exact multiple of 16 words. Single-port memory; one access per cycle.

## Interface
- `NUM_OF_WORDS`, 20: message length in 32-bit words; legal range 1..2^27-1.
- `clk`  in  1  sole clock; also drives `mem_clk`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sampled in IDLE only; starts one padding run.
- `message_addr`  in  16  word address of first source word; sampled with `start`.
- `padded_addr`  in  16  word address of first padded word; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done` pulses.
- `done`  out  1  one-cycle pulse after the final padded word is written.
- `mem_clk`  out  1  equals `clk`.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  16  word address.
- `mem_write_data`  out  32  write data.
- `mem_read_data`  in  32  read data, valid in the cycle after the address is presented (synchronous memory).

## Operation
- Block count B = floor((NUM_OF_WORDS+2)/16) + 1; padded length P = 16*B; pad words = P - NUM_OF_WORDS.
- States: IDLE, RD, WAIT, WR, PAD, FIN.
- IDLE: `start`=1 latches both addresses, clears word index i, goes to RD.
- RD: `mem_addr`=message_addr+i, `mem_we`=0 -> WAIT.
- WAIT: `mem_read_data` valid; captured into write-data register at the end of the cycle -> WR.
- WR: `mem_addr`=padded_addr+i, `mem_we`=1, `mem_write_data`=captured word; i++; if i now equals NUM_OF_WORDS -> PAD, else -> RD.
- PAD: one write per cycle at padded_addr+i, i++: index NUM_OF_WORDS gets 0x80000000; indices up to P-3 get 0; P-2 gets 0x00000000 (length high word); P-1 gets NUM_OF_WORDS*32 (length low word). After writing P-1 -> FIN.
- FIN: `mem_we`=0, `done`=1, `busy`=0 -> IDLE.
- Address arithmetic is 16-bit modulo; regions wrapping past 0xFFFF wrap silently. Overlapping source and destination regions are not supported.
- `start` outside IDLE is ignored; `start` held high in IDLE after FIN begins a new run.

## Timing
- Reset (async, immediate): state IDLE, `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0, i=0.
- `mem_we`, `mem_addr`, `mem_write_data` are driven combinationally from state and registers; `mem_we` is 0 in every state except WR and PAD.
- Taking the edge where `start` is sampled as edge 0: message copy occupies cycles 1..3*NUM_OF_WORDS; pad writes occupy the next P-NUM_OF_WORDS cycles; `done` is high in cycle 2*NUM_OF_WORDS+P+1.
- Reset mid-run: return to IDLE immediately; partially written padded region left as-is; no `done` pulse.

## Configuration
- `SHA_PAD_BSWAP_EN` defined: each copied message word is byte-reversed before it is written (little-endian source); marker, zero and length words are never swapped.
- Not defined: message words are copied unchanged.

## Test plan
- NUM_OF_WORDS=20, source words 0x00000001..0x00000014 -> padded words 0..19 identical, word 20 = 0x80000000, words 21..29 = 0, word 30 = 0, word 31 = 0x00000280; `done` in cycle 73; 32 writes total.
- NUM_OF_WORDS=13 -> single block: word 13 = 0x80000000, word 14 = 0, word 15 = 0x000001A0; `done` in cycle 43.
- NUM_OF_WORDS=14 (boundary) -> two blocks: word 14 = 0x80000000, words 15..30 = 0, word 31 = 0x000001C0.
- `start` pulsed during RD/PAD with different addresses -> ignored; run completes at the original addresses with a single `done` pulse.
- `reset_n` low in cycle 10 of an N=20 run -> all outputs at reset values in the same cycle; no further writes; fresh `start` completes correctly.
- With `SHA_PAD_BSWAP_EN`, source word 0x11223344 -> padded 0x44332211; marker still 0x80000000, length word unchanged.
